// File: rtl/engckmon.sv
// Receive-side monitor for the four-phase engine clock generator.
// Registers the rotating phase enables, acquires lock after a run of correct
// rotations, tracks the active phase, checks frame alignment, and keeps
// rotation-fault and frame-mismatch status for readout.
module engckmon #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             engclk,
  input  logic             rstb,
  input  logic [3:0]       phase_en,
  input  logic [1:0]       sync,
  input  logic             frm,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic             sync_ok,
  output logic             sync_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED
  } state_t;

  localparam logic [7:0]       LOCK_N  = 8'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t     state, nstate;
  logic [7:0] gcnt, gcnt_n, gnext;
  logic [3:0] phase_q, phase_qd;
  logic       onehot, good, fault, match, mism;
  logic [1:0] enc;

  // Rotation scoring and next-state selection from the two registered samples
  always_comb begin
    onehot = $onehot(phase_q);
    good   = onehot && (phase_q == {phase_qd[2:0], phase_qd[3]});
    gnext  = gcnt + 8'd1;
    nstate = state;
    gcnt_n = gcnt;
    fault  = 1'b0;
    unique case (phase_q)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
    case (state)
      S_IDLE: begin
        if (onehot) begin
          nstate = S_ACQ;
          gcnt_n = '0;
        end
      end
      S_ACQ: begin
        if (good) begin
          gcnt_n = gnext;
          if (gnext == LOCK_N) nstate = S_LOCKED;
        end else if (onehot) begin
          gcnt_n = '0;
        end else begin
          nstate = S_IDLE;
          gcnt_n = '0;
        end
      end
      S_LOCKED: begin
        if (!good) begin
          fault  = 1'b1;
          gcnt_n = '0;
          nstate = onehot ? S_ACQ : S_IDLE;
        end
      end
      default: begin
        nstate = S_IDLE;
        gcnt_n = '0;
      end
    endcase
    match = (enc == sync);
    mism  = frm && (state == S_LOCKED) && !match;
  end

  // Input stage, lock FSM and all registered status outputs
  always_ff @(posedge engclk or negedge rstb) begin
    if (!rstb) begin
      phase_q    <= '0;
      phase_qd   <= '0;
      state      <= S_IDLE;
      gcnt       <= '0;
      locked     <= 1'b0;
      phase      <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
      sync_ok    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      phase_q   <= phase_en;
      phase_qd  <= phase_q;
      state     <= nstate;
      gcnt      <= gcnt_n;
      locked    <= (nstate == S_LOCKED);
      phase     <= (nstate == S_LOCKED) ? enc : '0;
      err_pulse <= fault;

      // a fault coinciding with a clear leaves exactly that one fault recorded
      if (fault) begin
        if (clr_err)                err_cnt <= ERR_ONE;
        else if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end

      if (mism)         sync_err <= 1'b1;
      else if (clr_err) sync_err <= 1'b0;

      // leaving lock discards the last frame verdict before any new frame
      if ((state == S_LOCKED) && (nstate != S_LOCKED)) sync_ok <= 1'b0;
      else if (frm) sync_ok <= (state == S_LOCKED) && match;
    end
  end

endmodule
